// File: rtl/uart_report_pkg.sv
// Shared types, ASCII constants and sizing helpers for the UART report sender.
package uart_report_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [7:0] ASC_0    = 8'h30;
    localparam logic [7:0] ASC_SP   = 8'h20;
    localparam logic [7:0] ASC_STAR = 8'h2A;
    localparam logic [7:0] ASC_NL   = 8'h0A;

    // "ch" c " max " MAXSTR ", min " MINSTR "\n"
    function automatic int msg_len(input int digits);
        return 15 + 2 * digits;
    endfunction

    function automatic int pow10(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/uart_report_sender_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter; the first shift happens on the
// start edge, so the result is ready after exactly DATA_W edges.
module bin2bcd_seq #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [DATA_W-1:0]         bin,
    output logic [4*(DIGITS+1)-1:0]   bcd,
    output logic                      done
);

    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q;

    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] cur,
                                                 input logic             in_bit);
        logic [BCD_W-1:0] adj;
        // NOTE: blocking '=' belongs in functions and always_comb; clocked state uses '<='.
        adj = cur;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[BCD_W-2:0], in_bit};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            bcd      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd      <= dd_step('0, bin[DATA_W-1]);
                shift_q  <= bin << 1;
                cnt_q    <= CNT_W'(1);
                active_q <= (DATA_W > 1);
                done     <= (DATA_W == 1);
            end else if (active_q) begin
                bcd     <= dd_step(bcd, shift_q[DATA_W-1]);
                shift_q <= shift_q << 1;
                cnt_q   <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_report_sender.sv
// Round-robin multi-channel min/max report formatter feeding a UART TX FIFO push port.
// One shared converter handles max then min; the message is streamed byte by byte.
module uart_report_sender
    import uart_report_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int DIGITS     = 3,
    parameter int ZERO_BLANK = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH*DATA_W-1:0] max_val,
    input  logic [NUM_CH*DATA_W-1:0] min_val,
    input  logic                     tx_full,
    output logic                     tx_push,
    output logic [7:0]               tx_data,
    output logic                     busy,
    output logic [NUM_CH-1:0]        pending,
    output logic                     msg_done
);

    localparam int          MSG_LEN = msg_len(DIGITS);
    localparam int          IDX_W   = $clog2(MSG_LEN);
    localparam int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          MAX_POS = 8;
    localparam int          MIN_POS = MAX_POS + DIGITS + 6;
    localparam int unsigned LIMIT   = pow10(DIGITS) - 1;

    state_t               state_q;
    logic [CH_W-1:0]      ch_q, last_q, grant_ch;
    logic [IDX_W-1:0]     idx_q;
    logic                 phase_q;
    logic                 grant;
    logic [NUM_CH-1:0]    grant_mask;
    int                   dist_c, best_c, byte_i;

    logic [DATA_W-1:0]    max_sel, min_sel, min_snap_q, conv_bin;
    logic                 max_big_q, min_big_q, max_ovf_q, min_ovf_q, carry_ovf;
    logic [4*DIGITS-1:0]  max_dig_q, min_dig_q;
    logic [4*(DIGITS+1)-1:0] conv_bcd;
    logic                 conv_start, conv_done;

    // Round-robin pick: smallest distance from last_q+1 among pending channels.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant_ch = '0;
        best_c   = NUM_CH;
        dist_c   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            dist_c = (i + NUM_CH - int'(last_q) - 1) % NUM_CH;
            if (pending[i] && dist_c < best_c) begin
                best_c   = dist_c;
                grant_ch = CH_W'(i);
            end
        end
    end

    assign grant = (state_q == IDLE) && (|pending);

    always_comb begin
        max_sel    = '0;
        min_sel    = '0;
        grant_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_ch == CH_W'(i)) begin
                max_sel = max_val[i*DATA_W +: DATA_W];
                min_sel = min_val[i*DATA_W +: DATA_W];
            end
            grant_mask[i] = grant && (grant_ch == CH_W'(i));
        end
    end

    // Max converts straight from the inputs on the grant edge; min from its snapshot.
    assign conv_start = grant || (state_q == CONV && conv_done && !phase_q);
    assign conv_bin   = (state_q == IDLE) ? max_sel : min_snap_q;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (conv_bin),
        .bcd     (conv_bcd),
        .done    (conv_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ch_q    <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            phase_q <= 1'b0;
            pending <= '0;
        end else begin
            // A start in the grant cycle re-arms the request after it is cleared.
            pending <= (pending & ~grant_mask) | start;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= CONV;
                        ch_q    <= grant_ch;
                        last_q  <= grant_ch;
                        phase_q <= 1'b0;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                        end else begin
                            state_q <= SEND;
                            idx_q   <= '0;
                        end
                    end
                end
                SEND: begin
                    if (tx_push) begin
                        if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Carry nibble flags overflow within the converter's range; the compare covers
    // wide values that run past DIGITS+1 decimal places.
    assign carry_ovf = (conv_bcd[4*(DIGITS+1)-1 -: 4] != 4'd0);

    // NOTE: datapath registers need no reset; each is written before it is read.
    always_ff @(posedge clk) begin
        if (grant) begin
            min_snap_q <= min_sel;
            max_big_q  <= (32'(max_sel) > LIMIT);
            min_big_q  <= (32'(min_sel) > LIMIT);
        end
        if (state_q == CONV && conv_done) begin
            if (!phase_q) begin
                max_dig_q <= conv_bcd[4*DIGITS-1:0];
                max_ovf_q <= max_big_q || carry_ovf;
            end else begin
                min_dig_q <= conv_bcd[4*DIGITS-1:0];
                min_ovf_q <= min_big_q || carry_ovf;
            end
        end
    end

    function automatic logic [7:0] digit_char(input logic [4*DIGITS-1:0] dig,
                                              input logic                ovf,
                                              input int                  pos);
        logic [3:0] nib;
        logic       lead;
        nib  = 4'd0;
        lead = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k <= pos && dig[4*(DIGITS-1-k) +: 4] != 4'd0) lead = 1'b0;
            if (k == pos) nib = dig[4*(DIGITS-1-k) +: 4];
        end
        if (ovf) return ASC_STAR;
        if (ZERO_BLANK != 0 && lead && pos != DIGITS - 1) return ASC_SP;
        return ASC_0 + {4'd0, nib};
    endfunction

    function automatic logic [7:0] label_char(input int pos);
        case (pos)
            0:                  return "c";
            1:                  return "h";
            3:                  return " ";
            4:                  return "m";
            5:                  return "a";
            6:                  return "x";
            7:                  return " ";
            MAX_POS + DIGITS:   return ",";
            MAX_POS + DIGITS+1: return " ";
            MAX_POS + DIGITS+2: return "m";
            MAX_POS + DIGITS+3: return "i";
            MAX_POS + DIGITS+4: return "n";
            MAX_POS + DIGITS+5: return " ";
            default:            return 8'h00;
        endcase
    endfunction

    assign byte_i = int'(idx_q);

    always_comb begin
        tx_data = 8'h00;
        if (state_q == SEND) begin
            if (byte_i >= MAX_POS && byte_i < MAX_POS + DIGITS)
                tx_data = digit_char(max_dig_q, max_ovf_q, byte_i - MAX_POS);
            else if (byte_i >= MIN_POS && byte_i < MIN_POS + DIGITS)
                tx_data = digit_char(min_dig_q, min_ovf_q, byte_i - MIN_POS);
            else if (byte_i == 2)
                tx_data = ASC_0 + 8'(ch_q);
            else if (byte_i == MSG_LEN - 1)
                tx_data = ASC_NL;
            else
                tx_data = label_char(byte_i);
        end
    end

    assign tx_push  = (state_q == SEND) && !tx_full;
    assign msg_done = tx_push && (idx_q == IDX_W'(MSG_LEN - 1));
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/uart_report_sender.md
# uart_report_sender

Parametrised multi-channel report formatter. On a per-channel start request it snapshots that channel's max/min values, converts both to zero-padded or blank-padded decimal ASCII with a sequential binary-to-BCD converter, and pushes one fixed-format text line byte-by-byte into the UART TX FIFO push port. It sits between the sensor min/max trackers and `uart_controller`, and replaces the fixed two-mode temp/humi sender.

## Interface
- `NUM_CH`, default 2: number of channels, range 1..10; the channel index is printed as one digit.
- `DATA_W`, default 8: width of each value, unsigned.
- `DIGITS`, default 3: decimal characters per value, range 1..4.
- `ZERO_BLANK`, default 0: when 1, leading zeros print as spaces; the last digit is always printed.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  NUM_CH  per-channel report request, one-cycle pulse per bit.
- `max_val`  in  NUM_CH*DATA_W  channel c max value in bits [c*DATA_W +: DATA_W].
- `min_val`  in  NUM_CH*DATA_W  same packing as `max_val`.
- `tx_full`  in  1  TX FIFO full.
- `tx_push`  out  1  FIFO push strobe.
- `tx_data`  out  8  ASCII byte, valid when `tx_push` is high.
- `busy`  out  1  high in any state other than IDLE.
- `pending`  out  NUM_CH  latched requests not yet granted.
- `msg_done`  out  1  one-cycle pulse in the cycle the final byte is pushed.

## Operation
- Message format is `"ch" c " max " MAXSTR ", min " MINSTR "\n"`. Length is MSG_LEN = 15 + 2*DIGITS, which is 21 bytes at the defaults.
- Request latching: `pending[c]` is set on any `start[c]`. It clears at the cycle of grant. A start arriving in the same cycle as the grant of channel c wins, so `pending[c]` stays set. Repeated starts to a pending channel merge into one request. A start for the channel currently being sent sets pending, and that channel is re-sent later with fresh values.
- Arbitration: round-robin. The search starts at last_served+1 modulo NUM_CH. last_served resets to NUM_CH-1, so the first search starts at channel 0.
- FSM states and transitions:
  - IDLE → CONV when `pending` is nonzero. In that transition the block latches the channel number and snapshots `max_val`/`min_val`. Later input changes do not affect the message.
  - CONV → SEND after exactly 2*DATA_W cycles: DATA_W for max, then DATA_W for min, in one shared converter.
  - SEND: byte index 0..MSG_LEN-1. The index advances only on a push. After the last push the FSM returns to IDLE.
- Push rule: `tx_push` = (state==SEND) & ~`tx_full`. This is combinational from registered state and the `tx_full` input. No byte is lost or duplicated under backpressure.
- `tx_data` is a function of the byte index, the latched channel and the digit registers. It is 8'h00 outside SEND.
- Digits: ASCII = BCD + 8'h30.
  - Value > 10^DIGITS−1: all DIGITS characters are `*`.
  - ZERO_BLANK: leading zero digits become 8'h20, except the least significant digit.
- Mid-operation reset: the block aborts immediately. No further pushes occur, and all pending requests are lost.

## Timing
- Reset values:
  - Outputs: `tx_push`=0, `tx_data`=0, `busy`=0, `pending`=0, `msg_done`=0.
  - Internal: state IDLE, index 0.
- Latency, with `tx_full` low:
  - `start` is sampled at edge E0, and `pending` is visible after E0.
  - Grant happens at E1.
  - The first `tx_push` is high in the cycle following edge E1+2*DATA_W, i.e. 2*DATA_W+1 edges after E0 (17 cycles at the defaults).
  - One byte is pushed per cycle after that.
  - `msg_done` coincides with the `\n` push.
  - `busy` falls on the following edge.
- Back-to-back: the next grant occurs in the first IDLE cycle, with no extra gap. Per-message occupancy is 1 (IDLE) + 2*DATA_W + MSG_LEN cycles, not counting full stalls.
- `tx_full` is honoured in the same cycle. It is never pushed through.

## Structure
- Package `uart_report_pkg` holds:
  - the FSM state enum (IDLE, CONV, SEND);
  - ASCII constants (`ASC_0`, `ASC_SP`, `ASC_STAR`, `ASC_NL`);
  - the constant function `msg_len(DIGITS)`;
  - the function `pow10(DIGITS)` used for the overflow limit.
- Sub-module `bin2bcd_seq`:
  - implements shift-add-3 (double dabble) over DATA_W cycles;
  - ports: `start`, `bin` in, `bcd` out, `done` pulse;
  - carries DIGITS+1 BCD nibbles so that overflow can be detected.
- `uart_report_sender` contains the arbiter, the FSM and the byte mux.

## Test plan
- Defaults, ch0 max=37 min=5, `start`=2'b01: exactly 21 pushes, "ch0 max 037, min 005\n". First push 17 cycles after start. `msg_done` on the `\n` push.
- ZERO_BLANK=1, ch1 max=200 min=0: "ch1 max 200, min   0\n".
- DIGITS=2, ch0 max=123 min=99: "ch0 max **, min 99\n", 19 bytes.
- Hold `tx_full` high for 5 cycles at byte 8, and again at byte 20: the byte stream is unchanged, there are no pushes while full, and the total push count is 21.
- After ch0 is served, `start`=2'b11 in one cycle: ch1's message goes out first, then ch0's, back-to-back. `pending` goes 11→01→00. A start to ch1 during its own SEND causes a second ch1 message.
- Drop `reset_n` low at byte 10: `tx_push`, `busy` and `pending` go to 0 asynchronously. After release, no pushes occur until a new `start`.
